// File: rtl/centroid_frame_ctrl_pkg.sv
// Shared state type and sizing helpers for the centroid frame sequencer.
package centroid_pkg;
    typedef enum logic [2:0] {IDLE, FLUSH, STREAM, DRAIN, REPORT} state_t;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int FRAME_PIX = IMG_W_DEF * IMG_H_DEF;
    localparam int CX_W      = $clog2(IMG_W_DEF) + 1;
    localparam int PIXCNT_W  = $clog2(FRAME_PIX) + 1;

    function automatic int cx_width(input int img_w);
        return $clog2(img_w) + 1;
    endfunction

    function automatic int pixcnt_width(input int img_w, input int img_h);
        return $clog2(img_w * img_h) + 1;
    endfunction
endpackage

// File: rtl/centroid_frame_ctrl_lost_hysteresis.sv
// Saturating count of consecutive bad frames; flags track loss at the limit.
module lost_hysteresis #(
    parameter int LOST_LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic update,
    input  logic bad,
    output logic track_lost
);
    localparam int CW = $clog2(LOST_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(LOST_LIMIT);

    logic [CW-1:0] lost_cnt;
    logic [CW-1:0] cnt_next;

    // NOTE: give every always_comb output a default first so no path infers a latch.
    always_comb begin
        cnt_next = lost_cnt;
        if (!bad)
            cnt_next = '0;
        else if (lost_cnt != LIMIT)
            cnt_next = lost_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lost_cnt   <= '0;
            track_lost <= 1'b0;
        end else if (update) begin
            lost_cnt   <= cnt_next;
            track_lost <= (cnt_next == LIMIT);
        end
    end
endmodule

// File: rtl/centroid_frame_ctrl.sv
// Frame sequencer: flush, admit one frame of pixels, await the centroid with a
// timeout, then publish one hysteresis-filtered result per frame.
module centroid_frame_ctrl
    import centroid_pkg::*;
#(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int FLUSH_CYC   = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int LOST_LIMIT  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   src_valid,
    input  logic [11:0]            src_data,
    output logic                   src_ready,
    output logic [11:0]            pipe_data,
    output logic                   pipe_valid,
    output logic                   pipe_flush,
    input  logic [$clog2(IMG_W):0] cen_x,
    input  logic                   cen_valid,
    input  logic                   cen_lost,
    output logic [$clog2(IMG_W):0] result_x,
    output logic                   result_valid,
    output logic                   track_lost,
    output logic                   timeout_err,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);
    localparam int XW      = cx_width(IMG_W);
    localparam int PCW     = pixcnt_width(IMG_W, IMG_H);
    localparam int FLW     = $clog2(FLUSH_CYC + 1);
    localparam int TOW     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PCW-1:0] FRAME_LAST = PCW'(IMG_W * IMG_H);
    localparam logic [FLW-1:0] FL_LAST    = FLW'(FLUSH_CYC - 1);
    localparam logic [TOW-1:0] TO_LAST    = TOW'(TIMEOUT_CYC - 1);

    state_t         state;
    logic [PCW-1:0] pix_cnt;
    logic [FLW-1:0] flush_cnt;
    logic [TOW-1:0] drain_cnt;
    logic [XW-1:0]  cap_x;
    logic           cap_lost;
    logic           got;

    logic xfer, sample_cen, frame_done, frame_bad;

    assign src_ready  = (state == STREAM) && (pix_cnt < FRAME_LAST);
    assign busy       = (state != IDLE);
    assign xfer       = src_valid & src_ready;
    // Centroid values seen before the frame streams belong to the previous frame.
    assign sample_cen = cen_valid && ((state == STREAM) || (state == DRAIN));
    assign frame_done = (state == DRAIN) && (got || (drain_cnt == TO_LAST));
    assign frame_bad  = !got || cap_lost;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            pix_cnt      <= '0;
            flush_cnt    <= '0;
            drain_cnt    <= '0;
            cap_x        <= '0;
            cap_lost     <= 1'b0;
            got          <= 1'b0;
            pipe_data    <= '0;
            pipe_valid   <= 1'b0;
            pipe_flush   <= 1'b0;
            result_x     <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            pipe_valid   <= xfer;
            result_valid <= 1'b0;
            if (xfer)
                pipe_data <= src_data;
            if (sample_cen) begin
                cap_x    <= cen_x;
                cap_lost <= cen_lost;
                got      <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start || continuous) begin
                        state      <= FLUSH;
                        pipe_flush <= 1'b1;
                        flush_cnt  <= '0;
                        if (start)
                            timeout_err <= 1'b0;
                    end
                end
                FLUSH: begin
                    pix_cnt  <= '0;
                    got      <= 1'b0;
                    cap_lost <= 1'b0;
                    if (flush_cnt == FL_LAST) begin
                        state      <= STREAM;
                        pipe_flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer)
                        pix_cnt <= pix_cnt + 1'b1;
                    if (pix_cnt == FRAME_LAST) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (frame_done) begin
                        state        <= REPORT;
                        result_valid <= 1'b1;
                        frame_cnt    <= frame_cnt + 16'd1;
                        if (!frame_bad)
                            result_x <= cap_x;
                        if (!got)
                            timeout_err <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (continuous) begin
                        state      <= FLUSH;
                        pipe_flush <= 1'b1;
                        flush_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    lost_hysteresis #(
        .LOST_LIMIT(LOST_LIMIT)
    ) u_lost_hysteresis (
        .clk       (clk),
        .rst       (rst),
        .update    (frame_done),
        .bad       (frame_bad),
        .track_lost(track_lost)
    );
endmodule

// File: tb/tb_centroid_frame_ctrl.sv
// Scoreboard bench for centroid_frame_ctrl on an 8x4 frame with a centroid stub.
module tb_centroid_frame_ctrl;
    localparam int IMG_W = 8, IMG_H = 4, FLUSH_CYC = 4, TIMEOUT_CYC = 16, LOST_LIMIT = 3;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int XW   = 4;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, continuous = 1'b0;
    logic          src_valid = 1'b0;
    logic [11:0]   src_data = '0;
    logic          src_ready, pipe_valid, pipe_flush;
    logic [11:0]   pipe_data;
    logic [XW-1:0] cen_x = '0;
    logic          cen_valid = 1'b0, cen_lost = 1'b0;
    logic [XW-1:0] result_x;
    logic          result_valid, track_lost, timeout_err, busy;
    logic [15:0]   frame_cnt;

    typedef struct {
        logic [XW-1:0] x;
        logic          tl;
        logic          te;
        int            fc;
        int            lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] pix_q[$];
    exp_t        exp_m;
    logic [11:0] pix_m;

    int checks = 0, failures = 0;
    int cyc = 0, pv_frame = 0, fl_run = 0, results_seen = 0, last_pv_cyc = 0;
    int src_mode = 0, pix_idx = 0, rs_base = 0;
    logic          tog = 1'b0;
    logic          stub_on = 1'b0, stub_lost = 1'b0;
    logic [XW-1:0] stub_x = '0;

    centroid_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FLUSH_CYC(FLUSH_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .LOST_LIMIT(LOST_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .pipe_data(pipe_data), .pipe_valid(pipe_valid), .pipe_flush(pipe_flush),
        .cen_x(cen_x), .cen_valid(cen_valid), .cen_lost(cen_lost),
        .result_x(result_x), .result_valid(result_valid), .track_lost(track_lost),
        .timeout_err(timeout_err), .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int x, input int tl, input int te, input int fc, input int lat);
        exp_t e;
        e.x = XW'(x); e.tl = (tl != 0); e.te = (te != 0); e.fc = fc; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_rv(input string name, input int max);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (!result_valid && n < max);
        check(name, int'(result_valid), 1);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (busy && n < max);
        check(name, int'(busy), 0);
    endtask

    // Source: always-valid or alternating; records every pixel it knows will be accepted.
    initial begin
        forever begin
            @(negedge clk);
            tog       = ~tog;
            src_valid = (src_mode == 1) || (src_mode == 2 && tog);
            src_data  = 12'((pix_idx * 53 + 17) % 4096);
            if (src_valid && src_ready) begin
                pix_q.push_back(src_data);
                pix_idx++;
            end
        end
    end

    // Centroid stub: one cen_valid pulse two cycles after the frame's last pipe pixel.
    initial begin
        int cnt = 0;
        bit fired = 1'b0;
        forever begin
            @(negedge clk);
            cen_valid = 1'b0;
            if (pv_frame != NPIX) begin
                cnt = 0; fired = 1'b0;
            end else if (stub_on && !fired) begin
                cnt++;
                if (cnt == 2) begin
                    cen_valid = 1'b1; cen_x = stub_x; cen_lost = stub_lost; fired = 1'b1;
                end
            end
        end
    end

    // Monitor: flush length, pixel order, and per-frame results against the queues.
    always @(posedge clk) begin
        #1;
        if (pipe_flush) begin
            fl_run++;
            pv_frame = 0;
        end else if (fl_run > 0) begin
            check("flush_len", fl_run, FLUSH_CYC);
            fl_run = 0;
        end
        if (pipe_valid) begin
            pv_frame++;
            last_pv_cyc = cyc;
            if (pix_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL pipe_unexpected: pipe_valid with data %0d, no pixel pending", pipe_data);
            end else begin
                pix_m = pix_q.pop_front();
                check("pipe_data", int'(pipe_data), int'(pix_m));
            end
            if (pv_frame == NPIX)
                check("src_ready_after_last", int'(src_ready), 0);
        end
        if (result_valid) begin
            results_seen++;
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL result_unexpected: result_valid=1 x=%0d, none expected", result_x);
            end else begin
                exp_m = exp_q.pop_front();
                check("result_x", int'(result_x), int'(exp_m.x));
                check("track_lost", int'(track_lost), int'(exp_m.tl));
                check("timeout_err", int'(timeout_err), int'(exp_m.te));
                check("frame_cnt", int'(frame_cnt), exp_m.fc);
                check("pix_per_frame", pv_frame, NPIX);
                check("drain_latency", cyc - last_pv_cyc, exp_m.lat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        check("rst_busy", int'(busy), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_result_x", int'(result_x), 0);
        check("rst_flags", int'({result_valid, track_lost, timeout_err, pipe_flush, pipe_valid, src_ready}), 0);
        @(negedge clk); rst = 1'b1;

        // Frame 1: continuous source, stub answers x=5.
        src_mode = 1; stub_on = 1'b1; stub_x = 4'd5; stub_lost = 1'b0;
        push_exp(5, 0, 0, 1, 3);
        pulse_start();
        wait_rv("f1_result", 200);
        @(posedge clk); #1;
        check("f1_busy_falls", int'(busy), 0);
        check("f1_result_count", results_seen, 1);

        // Frame 2: source toggling 1/0.
        src_mode = 2; stub_x = 4'd3;
        push_exp(3, 0, 0, 2, 3);
        pulse_start();
        wait_rv("f2_result", 300);
        wait_idle("f2_idle", 5);

        // Three lost frames then a good one: track_lost 0,0,1,0.
        src_mode = 1; stub_lost = 1'b1; stub_x = 4'd7;
        for (int i = 0; i < 3; i++) begin
            push_exp(3, (i == 2) ? 1 : 0, 0, 3 + i, 3);
            pulse_start();
            wait_rv("lost_result", 200);
            wait_idle("lost_idle", 5);
        end
        stub_lost = 1'b0; stub_x = 4'd2;
        push_exp(2, 0, 0, 6, 3);
        pulse_start();
        wait_rv("good_result", 200);
        wait_idle("good_idle", 5);

        // Timeout: stub silent, result_x holds, sticky error.
        stub_on = 1'b0;
        push_exp(2, 0, 1, 7, TIMEOUT_CYC + 1);
        pulse_start();
        wait_rv("to_result", 200);
        wait_idle("to_idle", 5);
        repeat (3) @(posedge clk); #1;
        check("to_sticky", int'(timeout_err), 1);

        // Continuous run of three frames; start during STREAM is ignored.
        stub_on = 1'b1; stub_x = 4'd6;
        rs_base = results_seen;
        for (int i = 0; i < 3; i++) push_exp(6, 0, 0, 8 + i, 3);
        @(negedge clk); continuous = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        check("start_clears_to", int'(timeout_err), 0);
        n = 0;
        while (pv_frame < 5 && n < 200) begin @(posedge clk); #1; n++; end
        check("cont_reached_stream", int'(pv_frame >= 5), 1);
        pulse_start();
        wait_rv("cont_f1", 200);
        @(posedge clk); #1;
        check("cont_back_to_back", int'(pipe_flush), 1);
        wait_rv("cont_f2", 200);
        @(posedge clk); #1;
        @(negedge clk); continuous = 1'b0;
        wait_rv("cont_f3", 200);
        wait_idle("cont_idle", 5);
        repeat (60) @(posedge clk); #1;
        check("cont_stays_idle", int'(busy), 0);
        check("cont_result_count", results_seen - rs_base, 3);

        // Reset at pixel 10 discards the frame.
        stub_x = 4'd9;
        pulse_start();
        n = 0;
        while (pv_frame < 10 && n < 200) begin @(posedge clk); #1; n++; end
        check("rst_reached_pix10", pv_frame, 10);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_frame_cnt", int'(frame_cnt), 0);
        check("midrst_result_x", int'(result_x), 0);
        check("midrst_flags", int'({result_valid, track_lost, timeout_err, pipe_flush, pipe_valid, src_ready}), 0);
        @(negedge clk); rst = 1'b1;
        pix_q.delete();
        pv_frame = 0;
        rs_base = results_seen;
        repeat (50) @(posedge clk); #1;
        check("midrst_no_result", results_seen - rs_base, 0);
        push_exp(9, 0, 0, 1, 3);
        pulse_start();
        wait_rv("post_rst_result", 200);
        wait_idle("post_rst_idle", 5);

        repeat (5) @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/centroid_frame_ctrl.md
Name: centroid_frame_ctrl

Overview:
Frame sequencer for the rgb_to_grey -> edge_filter -> calc_centroid pipeline. It flushes the pipeline before each frame and admits exactly IMG_W*IMG_H pixels from the video source. It then waits, with a timeout, for the per-frame centroid result, applies lost-line hysteresis, and publishes one result per frame. It runs single-shot on start or continuously.

Parameters:
IMG_W, 640, pixels per row
IMG_H, 480, rows per frame
FLUSH_CYC, 4, cycles pipe_flush is held before each frame (>=1)
TIMEOUT_CYC, 4096, cycles allowed in DRAIN for cen_valid (>=1)
LOST_LIMIT, 3, consecutive bad frames before track_lost asserts (>=1)

Ports:
clk  in  1  single clock for the block
rst  in  1  reset; synchronous, active-low (asserted at 0)
start  in  1  single-cycle request to run one frame
continuous  in  1  level: when 1, start frames back-to-back
src_valid  in  1  source pixel present
src_data  in  12  source RGB444 pixel
src_ready  out  1  controller accepts a pixel this cycle
pipe_data  out  12  pixel to rgb_to_grey pixel_in
pipe_valid  out  1  to rgb_to_grey in_ready
pipe_flush  out  1  synchronous clear to the pipeline stages
cen_x  in  $clog2(IMG_W)+1  centroid_x from calc_centroid
cen_valid  in  1  line_valid from calc_centroid
cen_lost  in  1  line_lost from calc_centroid
result_x  out  $clog2(IMG_W)+1  last good centroid
result_valid  out  1  one-cycle pulse per completed frame
track_lost  out  1  hysteresis lost flag
timeout_err  out  1  sticky: a DRAIN timed out
busy  out  1  state != IDLE
frame_cnt  out  16  completed frames, wraps 0xFFFF->0

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE. All outputs 0, all counters 0, result_x 0. Reset applied mid-frame discards the frame, and no result_valid is produced for it.
- States:
  - IDLE -> FLUSH on (start | continuous).
  - FLUSH: pipe_flush=1 for FLUSH_CYC cycles, then -> STREAM.
  - STREAM -> DRAIN once pixel count reaches IMG_W*IMG_H.
  - DRAIN -> REPORT on result captured or timeout.
  - REPORT (1 cycle) -> FLUSH if continuous=1, else IDLE.
- start while busy=1 is ignored; it is not queued. Deasserting continuous mid-frame completes the current frame, then goes to IDLE.
- Stream handshake:
  - src_ready=1 only in STREAM while count < IMG_W*IMG_H, combinational from state and count.
  - Transfer = src_valid & src_ready.
  - pipe_valid and pipe_data are registered: pipe_valid = transfer delayed one cycle; pipe_data is loaded only on transfer.
  - Source gaps produce pipe_valid=0 cycles. There is no downstream backpressure.
  - The pixel counter is $clog2(IMG_W*IMG_H)+1 bits and clears in FLUSH.
- Result capture:
  - cen_valid is sampled in STREAM and DRAIN only; it is ignored in IDLE and FLUSH, since those values are stale.
  - On capture: store cen_x and cen_lost, and set got flag. Multiple captures in one frame: last wins.
  - DRAIN exits on the first cycle got=1, including when got was set during STREAM.
  - DRAIN counter counts from 0. If it reaches TIMEOUT_CYC-1 without capture, set timeout_err, treat the frame as lost, go to REPORT.
- REPORT:
  - result_valid=1 and frame_cnt+1.
  - Good frame (got & !lost): result_x <= captured x, lost_cnt <= 0.
  - Bad frame (lost or timeout): result_x holds, lost_cnt saturating +1.
  - track_lost = (lost_cnt == LOST_LIMIT), registered, updated in the same cycle as result_valid.
- timeout_err is cleared only by reset or by an accepted start.

Decomposition:
- Package centroid_pkg: state enum (IDLE, FLUSH, STREAM, DRAIN, REPORT); localparam FRAME_PIX = IMG_W*IMG_H; width helpers CX_W = $clog2(IMG_W)+1 and PIXCNT_W.
- Sub-module lost_hysteresis: saturating counter. Inputs: clk, rst, update, bad. Parameter: LOST_LIMIT. Output: track_lost.

Test Plan:
- IMG_W=8, IMG_H=4, src_valid=1, stub returns cen_valid with x=5 two cycles after the last pixel -> exactly 32 pipe_valid pulses; FLUSH lasts 4 cycles; result_x=5; one result_valid; frame_cnt=1; busy falls after REPORT.
- Same config, src_valid toggling 1/0 -> 32 pipe_valid pulses, pipe_data matches accepted src_data in order, src_ready=0 after the 32nd pixel.
- TIMEOUT_CYC=16, stub never responds -> REPORT 16 cycles into DRAIN; timeout_err=1; result_x unchanged; next accepted start clears timeout_err.
- LOST_LIMIT=3, frames lost, lost, lost, good(x=2) -> track_lost 0, 0, 1, 0; result_x 2 only after the fourth frame.
- continuous=1 for 3 frames, start pulsed during STREAM -> 3 back-to-back frames, frame_cnt=3, start has no effect; continuous dropped in frame 3 -> IDLE afterwards.
- rst=0 for 1 cycle at pixel 10 of a frame -> all outputs 0 the next cycle, no result_valid; a new start runs a full 32-pixel frame.
